// File: rtl/req_ack_latency_monitor_if.sv
// Handshake bundle for req_ack_latency_monitor.
// The master side owns the per-channel req/ack levels.
// The slave side is the monitor, which reports verdicts, counters and captured latencies.
interface req_ack_latency_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int LAT_W  = 8,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH-1:0]       pass_pulse;
    logic [NUM_CH-1:0]       fail_pulse;
    logic [2*NUM_CH-1:0]     fail_code;
    logic [CNT_W-1:0]        pass_cnt;
    logic [CNT_W-1:0]        fail_cnt;
    logic [LAT_W*NUM_CH-1:0] last_lat;

    modport master (
        output req, ack,
        input  pass_pulse, fail_pulse, fail_code, pass_cnt, fail_cnt, last_lat
    );

    modport slave (
        input  req, ack,
        output pass_pulse, fail_pulse, fail_code, pass_cnt, fail_cnt, last_lat
    );
endinterface

// File: rtl/req_ack_latency_monitor.sv
// Multi-channel REQ->ACK latency monitor.
// Each channel measures the number of clock edges from a sampled req rise to a sampled ack rise.
// It judges that latency against the window [MIN_LAT, MAX_LAT].
// Each verdict is a one-cycle pass or fail pulse with a fail code:
//   1 = early, 2 = late/timeout, 3 = protocol (ack without req, or overlapping req).
// pass_cnt and fail_cnt are saturating totals over all channels.
// Optional macro LAT_CAPTURE_EN adds per-channel last_lat capture registers.
// Without it, last_lat is tied to 0.
module req_ack_latency_monitor #(
    parameter int NUM_CH  = 4,
    parameter int MIN_LAT = 5,
    parameter int MAX_LAT = 5,
    parameter int LAT_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    req_ack_latency_monitor_if.slave  bus
);

    // Wide enough to add a full counter and a full-channel popcount without overflow.
    localparam int SUM_W = CNT_W + $clog2(NUM_CH + 1);
    localparam logic [SUM_W-1:0] CNT_MAX     = SUM_W'({CNT_W{1'b1}});
    localparam logic [LAT_W-1:0] MIN_L       = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] TIMEOUT_LAT = LAT_W'(MAX_LAT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state     [NUM_CH];
    state_t             state_nxt [NUM_CH];
    logic [LAT_W-1:0]   lat       [NUM_CH];
    logic [LAT_W-1:0]   lat_nxt   [NUM_CH];

    logic [NUM_CH-1:0]   req_q, ack_q;
    logic [NUM_CH-1:0]   rose_req, rose_ack;
    logic [NUM_CH-1:0]   pass_d, fail_d;
    logic [2*NUM_CH-1:0] code_d;

    logic [NUM_CH-1:0]   pass_r, fail_r;
    logic [2*NUM_CH-1:0] code_r;
    logic [CNT_W-1:0]    pass_total, fail_total;

    // Number of channels that reached a given verdict on this edge.
    function automatic logic [SUM_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + SUM_W'(v[i]);
        end
        return n;
    endfunction

    // Adds in the wide domain, then clamps to the all-ones counter value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cur,
                                                 input logic [SUM_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cur) + inc;
        if (sum > CNT_MAX) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    assign rose_req = bus.req & ~req_q;
    assign rose_ack = bus.ack & ~ack_q;

    // Per-channel verdict and next-state decode. Ack judgement and timeout win over overlap reporting.
    always_comb begin
        pass_d = '0;
        fail_d = '0;
        code_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i] = state[i];
            lat_nxt[i]   = lat[i];
            case (state[i])
                IDLE: begin
                    if (rose_ack[i]) begin
                        fail_d[i]         = 1'b1;
                        code_d[2*i +: 2]  = 2'd3;
                    end
                    if (rose_req[i]) begin
                        state_nxt[i] = WAIT;
                        lat_nxt[i]   = LAT_W'(1);
                    end
                end
                WAIT: begin
                    if (rose_ack[i] || lat[i] == TIMEOUT_LAT) begin
                        if (lat[i] == TIMEOUT_LAT) begin
                            fail_d[i]        = 1'b1;
                            code_d[2*i +: 2] = 2'd2;
                        end else if (lat[i] < MIN_L) begin
                            fail_d[i]        = 1'b1;
                            code_d[2*i +: 2] = 2'd1;
                        end else begin
                            pass_d[i] = 1'b1;
                        end
                        // A req rising on the deciding edge starts a fresh measurement.
                        if (rose_req[i]) begin
                            lat_nxt[i] = LAT_W'(1);
                        end else begin
                            state_nxt[i] = IDLE;
                        end
                    end else if (rose_req[i]) begin
                        fail_d[i]        = 1'b1;
                        code_d[2*i +: 2] = 2'd3;
                        lat_nxt[i]       = LAT_W'(1);
                    end else begin
                        lat_nxt[i] = lat[i] + LAT_W'(1);
                    end
                end
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    // History, channel FSMs, registered verdict pulses and saturating totals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= '0;
            ack_q      <= '0;
            pass_r     <= '0;
            fail_r     <= '0;
            code_r     <= '0;
            pass_total <= '0;
            fail_total <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= IDLE;
                lat[i]   <= '0;
            end
        end else begin
            req_q      <= bus.req;
            ack_q      <= bus.ack;
            pass_r     <= pass_d;
            fail_r     <= fail_d;
            code_r     <= code_d;
            pass_total <= sat_add(pass_total, popcount(pass_d));
            fail_total <= sat_add(fail_total, popcount(fail_d));
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= state_nxt[i];
                lat[i]   <= lat_nxt[i];
            end
        end
    end

    assign bus.pass_pulse = pass_r;
    assign bus.fail_pulse = fail_r;
    assign bus.fail_code  = code_r;
    assign bus.pass_cnt   = pass_total;
    assign bus.fail_cnt   = fail_total;

`ifdef LAT_CAPTURE_EN
    logic [LAT_W-1:0] cap [NUM_CH];

    // Latch the judged latency on pass/early; a timeout records MAX_LAT+1; protocol fails leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pass_d[i] || code_d[2*i +: 2] == 2'd1) begin
                    cap[i] <= lat[i];
                end else if (code_d[2*i +: 2] == 2'd2) begin
                    cap[i] <= TIMEOUT_LAT;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_last_lat
        assign bus.last_lat[g*LAT_W +: LAT_W] = cap[g];
    end
`else
    assign bus.last_lat = '0;
`endif

endmodule

// File: doc/req_ack_latency_monitor.md
Name: req_ack_latency_monitor

Overview:
- Synthesizable, multi-channel REQ→ACK latency checker.
- Generalises the single-channel "ACK exactly N after REQ" property into per-channel windowed measurement: pass/fail pulses, failure classification and saturating aggregate counters.
- Sits beside handshake interfaces as an in-design monitor, readable by testbenches and debug logic.

Parameters:
- NUM_CH, 4: number of independent req/ack channel pairs.
- MIN_LAT, 5: minimum legal latency in clock edges (≥1).
- MAX_LAT, 5: maximum legal latency in clock edges (≥MIN_LAT); MIN_LAT=MAX_LAT means exact match.
- LAT_W, 8: latency counter width; MAX_LAT+1 must be < 2**LAT_W.
- CNT_W, 16: width of the aggregate pass/fail counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_CH  per-channel request level.
- ack  in  NUM_CH  per-channel acknowledge level.
- pass_pulse  out  NUM_CH  one-cycle pulse: measurement within window.
- fail_pulse  out  NUM_CH  one-cycle pulse: measurement or protocol failure.
- fail_code  out  2*NUM_CH  per-channel code valid with fail_pulse; channel i at [2i+1:2i].
- pass_cnt  out  CNT_W  saturating total passes, all channels.
- fail_cnt  out  CNT_W  saturating total fails, all channels.
- last_lat  out  LAT_W*NUM_CH  last measured latency per channel (optional feature).

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high.
  - Asserting rst immediately clears every output, counter, channel FSM and the req/ack history registers to 0.
  - Deassertion is used synchronously.
- Edge detect: rose_req[i] = req[i] & ~req_q[i]; rose_ack[i] likewise. req_q/ack_q are sampled each clk edge.
- Per-channel FSM:
  - States: IDLE, WAIT.
  - lat counter, LAT_W bits.
- IDLE:
  - rose_req → WAIT, lat ← 1.
  - rose_ack (no outstanding req) → fail, code 3 (protocol).
  - Both on the same edge → code 3 fail for the ack, and WAIT entered for the req.
- WAIT, each edge:
  - rose_ack: judge lat. lat<MIN_LAT → fail code 1 (early); otherwise pass. Then IDLE.
  - No rose_ack and lat == MAX_LAT+1: fail code 2 (late/timeout), then IDLE. Timeout therefore fires at edge T+MAX_LAT+1, where T is the edge that sampled rose_req.
  - rose_ack at that same edge is judged code 2, not pass.
  - rose_req without rose_ack: fail code 3 (overlap) for the outstanding request; stay WAIT, lat ← 1.
  - rose_req with rose_ack: judge the current measurement normally, then stay WAIT, lat ← 1.
  - Otherwise lat ← lat+1.
- Latency definition: ack rise sampled L edges after the req-rise edge ⇒ latency L. Example: 10 ns clock, 50 ns ⇒ L=5.
- Outputs:
  - Registered. pass_pulse/fail_pulse/fail_code are high in the cycle after the deciding edge, for exactly one cycle.
  - fail_code is 0 when fail_pulse is 0.
  - pass_pulse and fail_pulse are never both high on one channel.
- Counters:
  - pass_cnt += popcount(pass decisions); fail_cnt += popcount(fail decisions), on the same edge as the pulses.
  - Saturate at 2**CNT_W-1; no wrap.
  - Summation is done in width CNT_W+$clog2(NUM_CH+1) before clamping.
- Channels are fully independent; any combination of events on any channels in the same cycle is legal.
- req/ack levels are not checked for deassertion ordering; only rising edges matter.

Optional Feature:
- Macro: LAT_CAPTURE_EN.
- Defined:
  - last_lat[i] loads the judged latency on every pass and on every early fail (code 1).
  - On code 2 it loads MAX_LAT+1.
  - On code 3 it is unchanged.
  - Cleared by rst.
- Undefined: no capture registers; last_lat is tied to 0. The port remains present.

Test Plan:
- NUM_CH=1, MIN=MAX=5: req rises, ack rises 5 edges later → pass_pulse 1 cycle, pass_cnt=1, fail_cnt=0, last_lat=5 (with LAT_CAPTURE_EN).
- Same config, ack at 4 edges → fail_pulse, fail_code=1. Ack never arrives → fail_code=2 exactly at edge T+6. MIN=4, MAX=6 with random 4..6 delays ×5 → pass_cnt=5.
- Ack rises with no prior req → fail code 3. Second req rise while waiting → code 3, new measurement from that edge; its ack 5 edges later → pass.
- NUM_CH=4: all channels pass on the same edge → pass_cnt increments by 4 in one cycle. Mixed 2 pass / 2 fail → both counters +2.
- rst asserted mid-WAIT (asynchronously, between edges) → outputs 0 immediately. Subsequent ack rise → code 3 fail, not pass.
- CNT_W=2: 5 passes → pass_cnt holds at 3.
